// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Multiply/divide sequencer for the 5-stage pipeline. Owns the architectural
// HI/LO pair, launches mult/multu/div/divu from EX and holds the unit busy
// for a fixed number of cycles before committing the result to HI/LO.
// mthi/mtlo write HI/LO directly at the EX edge without occupying the unit.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports
//   clk       in   pipeline clock
//   reset     in   synchronous active-high reset, clears all state
//   start     in   EX holds a valid MD op this cycle
//   op        in   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                  7 reserved (treated as none)
//   rs_data   in   forwarded rs operand in EX
//   rt_data   in   forwarded rt operand in EX
//   md_in_id  in   ID holds an MD-class instruction
//   busy      out  multi-cycle operation in progress (registered)
//   hi, lo    out  architectural HI/LO (registered)
//   md_stall  out  stall request to ID (combinational)
// ---------------------------------------------------------------------------
module md_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_in_id,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_stall
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [3:0]  count_reg;
    logic [2:0]  op_reg;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic        busy_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    // -----------------------------------------------------------------------
    // Result datapath, driven only by the operands latched at launch so that
    // whatever EX presents during the busy window cannot disturb the result.
    // -----------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic [31:0] div_den_safe;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        neg_quot;
    logic        neg_rem;

    // Low 64 bits of an unsigned product of sign-extended operands equal the
    // two's-complement signed product.
    assign prod_s = {{32{a_reg[31]}}, a_reg} * {{32{b_reg[31]}}, b_reg};
    assign prod_u = {32'd0, a_reg} * {32'd0, b_reg};

    // Signed divide runs on magnitudes and re-applies signs afterwards:
    // quotient negative when operand signs differ, remainder takes the
    // dividend's sign. 0x80000000 has magnitude 0x80000000 as an unsigned
    // value, so 0x80000000 / -1 naturally yields lo=0x80000000, hi=0.
    assign div_signed   = (op_reg == OP_DIV);
    assign div_num      = (div_signed && a_reg[31]) ? (32'd0 - a_reg) : a_reg;
    assign div_den      = (div_signed && b_reg[31]) ? (32'd0 - b_reg) : b_reg;
    // Keep the divider defined on a zero divisor; that result is never committed.
    assign div_den_safe = (div_den == 32'd0) ? 32'd1 : div_den;
    assign quot_mag     = div_num / div_den_safe;
    assign rem_mag      = div_num % div_den_safe;
    assign neg_quot     = div_signed & (a_reg[31] ^ b_reg[31]);
    assign neg_rem      = div_signed & a_reg[31];
    assign quot         = neg_quot ? (32'd0 - quot_mag) : quot_mag;
    assign rem          = neg_rem  ? (32'd0 - rem_mag)  : rem_mag;

    // -----------------------------------------------------------------------
    // Stall: an MD-class instruction in ID must wait while the unit is busy,
    // and also in the launch cycle itself, since busy only rises next cycle.
    // -----------------------------------------------------------------------
    logic launch_op;

    assign launch_op = start & ((op == OP_MULT) | (op == OP_MULTU) |
                                (op == OP_DIV)  | (op == OP_DIVU));
    assign md_stall  = md_in_id & (busy_reg | launch_op);

    // -----------------------------------------------------------------------
    // Sequencer FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            busy_reg  <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                op_reg    <= op;
                                a_reg     <= rs_data;
                                b_reg     <= rt_data;
                                count_reg <= 4'(MULT_CYCLES);
                                busy_reg  <= 1'b1;
                                state_reg <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                op_reg    <= op;
                                a_reg     <= rs_data;
                                b_reg     <= rt_data;
                                count_reg <= 4'(DIV_CYCLES);
                                busy_reg  <= 1'b1;
                                state_reg <= RUN;
                            end
                            OP_MTHI: hi_reg <= rs_data;
                            OP_MTLO: lo_reg <= rs_data;
                            default: ;
                        endcase
                    end
                end

                RUN: begin
                    // start is deliberately ignored here; md_stall keeps the
                    // pipeline from issuing one legally.
                    if (count_reg == 4'd1) begin
                        case (op_reg)
                            OP_MULT: begin
                                hi_reg <= prod_s[63:32];
                                lo_reg <= prod_s[31:0];
                            end
                            OP_MULTU: begin
                                hi_reg <= prod_u[63:32];
                                lo_reg <= prod_u[31:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                // Divide by zero leaves HI/LO untouched but
                                // still consumed the full busy window.
                                if (b_reg != 32'd0) begin
                                    hi_reg <= rem;
                                    lo_reg <= quot;
                                end
                            end
                            default: ;
                        endcase
                        count_reg <= 4'd0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Self-checking bench for md_sequencer. A behavioural model keeps HI/LO as
// plain variables and computes results with 64-bit integer arithmetic; each
// transaction checks the launch-cycle stall, busy/stall over every busy
// cycle, and HI/LO/busy in the first free cycle. Inputs are driven and
// outputs sampled mid-cycle, away from the rising edge.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        md_in_id;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_stall;

    int n_cmp = 0;
    int n_err = 0;

    // Reference architectural state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    always #5 clk = ~clk;

    md_sequencer #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .md_in_id (md_in_id),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_stall (md_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int latency(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MULT_N;
        if (o == 3'd3 || o == 3'd4) return DIV_N;
        return 0;
    endfunction

    // Architectural effect of one accepted op, in plain integer arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint          q;
        longint          r;
        longint unsigned pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd1: begin
                p = sa * sb;
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                m_hi = pu[63:32];
                m_lo = pu[31:0];
            end
            3'd3: if (b != 32'd0) begin
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Called mid-cycle with the previous transaction's checks done; the
    // launch happens in that same cycle, so back-to-back starts are covered.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic id, input bit inject);
        int   n;
        logic launches;
        n        = latency(o);
        launches = (o >= 3'd1 && o <= 3'd4);
        start    = 1'b1;
        op       = o;
        rs_data  = a;
        rt_data  = b;
        md_in_id = id;
        #1;
        chk("stall_launch", 32'(md_stall), 32'(id & launches));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            // Scramble EX inputs so a result that depends on live operands shows up.
            start   = (inject && k == 2) ? 1'b1 : 1'b0;
            op      = 3'($urandom_range(1, 7));
            rs_data = $urandom;
            rt_data = $urandom;
            #1;
            chk("busy_run", 32'(busy), 32'd1);
            chk("stall_run", 32'(md_stall), 32'(id));
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'd0;
        model_apply(o, a, b);
        #1;
        chk("busy_done", 32'(busy), 32'd0);
        chk("stall_done", 32'(md_stall), 32'd0);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        $display("op=%0d rs=%h rt=%h id=%0d inj=%0d -> hi=%h lo=%h",
                 o, a, b, id, inject, m_hi, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        md_in_id = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);

        // Directed cases
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_hi_k", hi, 32'hFFFF_FFFF);
        chk("mult_lo_k", lo, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        chk("multu_hi_k", hi, 32'h0000_0001);
        chk("multu_lo_k", lo, 32'hFFFF_FFFE);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        chk("div_hi_k", hi, 32'hFFFF_FFFF);
        chk("div_lo_k", lo, 32'hFFFF_FFFD);
        run_op(3'd4, 32'd1234, 32'd0, 1'b0, 1'b0);
        chk("divz_hi_k", hi, 32'hFFFF_FFFF);
        chk("divz_lo_k", lo, 32'hFFFF_FFFD);
        run_op(3'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        chk("mthi_k", hi, 32'h1234_5678);
        run_op(3'd6, 32'hCAFE_F00D, 32'd0, 1'b1, 1'b0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        chk("ovf_hi_k", hi, 32'h0000_0000);
        chk("ovf_lo_k", lo, 32'h8000_0000);
        run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        run_op(3'd0, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0);
        run_op(3'd7, 32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);

        // Reset in the third busy cycle of a div abandons it and clears HI/LO.
        start    = 1'b1;
        op       = 3'd3;
        rs_data  = 32'd100;
        rt_data  = 32'd7;
        md_in_id = 1'b1;
        #1;
        chk("rstdiv_launch_stall", 32'(md_stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("rstdiv_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        chk("rstdiv_busy2", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstdiv_busy3", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        #1;
        chk("rstdiv_busy", 32'(busy), 32'd0);
        chk("rstdiv_hi", hi, m_hi);
        chk("rstdiv_lo", lo, m_lo);
        chk("rstdiv_stall", 32'(md_stall), 32'd0);
        $display("reset during div -> hi=%h lo=%h", m_hi, m_lo);
        run_op(3'd1, 32'd6, 32'd7, 1'b1, 1'b0);

        // Randomized transactions, some separated by idle cycles.
        for (int t = 0; t < 120; t++) begin
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if ((o == 3'd3) && ($urandom_range(0, 7) == 0)) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            run_op(o, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
